if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of queue entries; legal values 2, 4, 8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  IF stage presents a fetched instruction.
REQ-005 SHALL have port in_ready  output  1  queue accepts an entry this cycle.
REQ-006 SHALL have port in_pc  input  32  PC of the presented instruction.
REQ-007 SHALL have port in_instr  input  32  presented instruction word.
REQ-008 SHALL have port flush  input  1  discard all entries (taken branch/jump redirect).
REQ-009 SHALL have port out_valid  output  1  head entry available to the ID stage.
REQ-010 SHALL have port out_ready  input  1  ID stage consumes the head entry.
REQ-011 SHALL have port out_pc  output  32  PC of head entry.
REQ-012 SHALL have port out_instr  output  32  instruction of head entry.
REQ-013 SHALL have port out_pc_plus4  output  32  out_pc + 4, modulo 2^32.
REQ-014 SHALL have port count  output  log2(DEPTH)+1  number of valid entries.

Function
REQ-015 Push SHALL occur when in_valid and in_ready are both 1 at a rising edge; pop when out_valid and out_ready are both 1.
REQ-016 in_ready SHALL be 1 exactly when count < DEPTH, independent of out_ready and flush.
REQ-017 out_valid SHALL be 1 exactly when count > 0 (bypass excepted, REQ-027).
REQ-018 Entries SHALL leave in push order (FIFO); no entry is duplicated or dropped except by flush.
REQ-019 Read and write pointers SHALL wrap modulo DEPTH; full vs. empty SHALL be distinguished by count, not pointer equality.
REQ-020 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-021 Push when full SHALL be impossible (in_ready=0); in_valid held high SHALL be accepted on the first cycle count < DEPTH.
REQ-022 Pop when empty SHALL be ignored; out_ready=1 with count=0 SHALL change no state.
REQ-023 flush=1 at a rising edge SHALL set count to 0 and both pointers to 0; a push or pop in the same cycle SHALL be discarded (flush has priority).
REQ-024 When out_valid=0, out_pc, out_instr and out_pc_plus4 SHALL all read 32'h00000000.
REQ-025 Without bypass, latency from push to out_valid SHALL be exactly one cycle.

Reset
REQ-026 rst=0 SHALL asynchronously force count=0, pointers=0, out_valid=0, in_ready=1, out_pc=out_instr=out_pc_plus4=0; storage contents need not be cleared; normal operation resumes on the first rising edge after rst returns to 1.

Configuration
REQ-027 With macro IF_ID_BYPASS_EN defined: when count=0, in_valid=1 and flush=0, out_valid SHALL be 1 combinationally with out_pc=in_pc, out_instr=in_instr; if out_ready=1 the entry SHALL pass through without being stored (count stays 0), else it SHALL be stored normally.
REQ-028 Without IF_ID_BYPASS_EN, no combinational path SHALL exist from in_* to out_*, and REQ-025 latency applies.

Verification
REQ-029 Reset: assert rst=0 mid-operation with count=2 -> count=0, out_valid=0, in_ready=1, outputs 0, immediately without waiting for clk.
REQ-030 Fill/drain: out_ready=0, push PC 0x00,0x04 (instr 0x11111111,0x22222222) -> count=2, in_ready=0; then out_ready=1 -> out_pc 0x00 then 0x04, out_pc_plus4 0x04 then 0x08, count 1 then 0.
REQ-031 Wrap: DEPTH=2, stream 6 pushes with continuous out_ready=1 -> PCs 0x00..0x14 emerge in order, none lost, count never exceeds 2.
REQ-032 Flush: count=2 with in_valid=1 and flush=1 same cycle -> next cycle count=0, out_valid=0; the concurrently presented entry never appears at out.
REQ-033 Wrap arithmetic: push in_pc=0xFFFFFFFC -> out_pc_plus4=0x00000000.
REQ-034 Bypass: with IF_ID_BYPASS_EN, empty queue, in_valid=1, in_pc=0x40, out_ready=1 -> same-cycle out_valid=1, out_pc=0x40, count stays 0; without the macro out_valid=0 that cycle and 1 the next.

Source files
------------

// File: rtl/if_id_queue.sv
//==============================================================================
// Module : if_id_queue
// IF->ID instruction FIFO (PC + instr); IF_ID_BYPASS_EN adds empty-queue bypass.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module if_id_queue #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc_plus4,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int              C_AW   = $clog2(DEPTH);
    localparam logic [C_AW:0]   C_FULL = (C_AW + 1)'(DEPTH);

    logic [31:0]     r_pc_mem    [DEPTH];
    logic [31:0]     r_instr_mem [DEPTH];
    logic [C_AW-1:0] r_rd_ptr;
    logic [C_AW-1:0] r_wr_ptr;
    logic [C_AW:0]   r_count;

    logic            w_head_valid;
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;
    logic            w_store;
    logic            w_deq;
    logic [31:0]     w_sel_pc;
    logic [31:0]     w_sel_instr;

    assign w_head_valid = (r_count != '0);

`ifdef IF_ID_BYPASS_EN
    // Gated by rst so the bypass cannot raise out_valid while reset is held.
    assign w_bypass    = rst & in_valid & ~flush & ~w_head_valid;
    assign w_sel_pc    = w_head_valid ? r_pc_mem[r_rd_ptr]    : in_pc;
    assign w_sel_instr = w_head_valid ? r_instr_mem[r_rd_ptr] : in_instr;
`else
    assign w_bypass    = 1'b0;
    assign w_sel_pc    = r_pc_mem[r_rd_ptr];
    assign w_sel_instr = r_instr_mem[r_rd_ptr];
`endif

    assign in_ready     = (r_count < C_FULL);
    assign out_valid    = w_head_valid | w_bypass;
    assign out_pc       = out_valid ? w_sel_pc          : 32'h0000_0000;
    assign out_instr    = out_valid ? w_sel_instr       : 32'h0000_0000;
    assign out_pc_plus4 = out_valid ? w_sel_pc + 32'd4  : 32'h0000_0000;
    assign count        = r_count;

    assign w_push  = in_valid & in_ready;
    assign w_pop   = out_valid & out_ready;
    // A bypassed entry consumed in the same cycle is never written to storage.
    assign w_store = w_push & ~(w_bypass & out_ready);
    assign w_deq   = w_pop & w_head_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + C_AW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + C_AW'(1);
            end
            r_count <= r_count + (C_AW + 1)'(w_store) - (C_AW + 1)'(w_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && w_store) begin
            r_pc_mem[r_wr_ptr]    <= in_pc;
            r_instr_mem[r_wr_ptr] <= in_instr;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_id_queue.sv
//==============================================================================
// Module : tb_if_id_queue
// Scoreboard bench for if_id_queue: queue reference model, directed + random.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_if_id_queue;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_pc_plus4;
    logic [$clog2(DEPTH):0] count;

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_pc_plus4 (out_pc_plus4),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   bypassed;
    bit   bypass_en;

    initial begin
`ifdef IF_ID_BYPASS_EN
        bypass_en = 1'b1;
`else
        bypass_en = 1'b0;
`endif
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs with the reference queue once per cycle
    // and retires entries the ID stage consumes.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            begin
                bit          exp_byp;
                bit          exp_valid;
                logic [31:0] exp_pc;
                logic [31:0] exp_instr;
                exp_byp   = bypass_en && rst && q.size() == 0 && in_valid && !flush;
                exp_valid = (q.size() > 0) || exp_byp;
                exp_pc    = 32'h0;
                exp_instr = 32'h0;
                if (q.size() > 0) begin
                    exp_pc    = q[0].pc;
                    exp_instr = q[0].instr;
                end else if (exp_byp) begin
                    exp_pc    = in_pc;
                    exp_instr = in_instr;
                end
                chk("count", 32'(count), 32'(q.size()));
                chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
                chk("out_valid", 32'(out_valid), 32'(exp_valid));
                chk("out_pc", out_pc, exp_pc);
                chk("out_instr", out_instr, exp_instr);
                chk("out_pc_plus4", out_pc_plus4, exp_valid ? exp_pc + 32'd4 : 32'h0);
                if (exp_valid && out_ready && !flush && rst) begin
                    if (q.size() > 0) void'(q.pop_front());
                    else bypassed = 1'b1;
                end
            end
        end
    end

    // Driver: one cycle of stimulus, then the reference model's push/flush.
    task automatic cycle(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                         input bit ordy, input bit fl);
        int pre_size;
        @(negedge clk);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        bypassed  = 1'b0;
        pre_size  = q.size();
        #2;
        if (rst) begin
            if (fl) q.delete();
            else if (v && pre_size < DEPTH && !bypassed) q.push_back('{pc: pc, instr: ins});
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        flush = 1'b0; out_ready = 1'b0; bypassed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Fill then drain
        cycle(1, 32'h00, 32'h1111_1111, 0, 0);
        cycle(1, 32'h04, 32'h2222_2222, 0, 0);
        @(posedge clk); #1;
        chk("fill_count", 32'(count), 32'd2);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        cycle(0, 32'h0, 32'h0, 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);

        // Asynchronous reset with two entries held
        cycle(1, 32'h100, 32'hAAAA_0001, 0, 0);
        cycle(1, 32'h104, 32'hAAAA_0002, 0, 0);
        @(posedge clk); #2;
        chk("pre_reset_count", 32'(count), 32'd2);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("areset_count", 32'(count), 32'd0);
        chk("areset_out_valid", 32'(out_valid), 32'd0);
        chk("areset_in_ready", 32'(in_ready), 32'd1);
        chk("areset_out_pc", out_pc, 32'h0);
        chk("areset_out_instr", out_instr, 32'h0);
        chk("areset_out_pc_plus4", out_pc_plus4, 32'h0);
        q.delete();
        @(negedge clk);
        rst = 1'b1;

        // Streaming through the pointer wrap
        for (int i = 0; i < 6; i++) cycle(1, 32'(i * 4), 32'hB000_0000 + 32'(i), 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);

        // Flush with a concurrent push
        cycle(1, 32'h300, 32'hC000_0000, 0, 0);
        cycle(1, 32'h304, 32'hC000_0001, 0, 0);
        cycle(1, 32'h308, 32'hC000_0002, 0, 1);
        @(posedge clk); #1;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        cycle(0, 32'h0, 32'h0, 1, 0);

        // PC + 4 modulo 2^32
        cycle(1, 32'hFFFF_FFFC, 32'hD000_0000, 0, 0);
        @(posedge clk); #1;
        chk("wrap_pc_plus4", out_pc_plus4, 32'h0000_0000);
        cycle(0, 32'h0, 32'h0, 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);

        // Empty queue, consumer ready: bypass or one-cycle latency
        cycle(1, 32'h40, 32'hE000_0000, 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 7, $urandom & 32'hFFFF_FFFC, $urandom,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
        end
        repeat (DEPTH + 2) cycle(0, 32'h0, 32'h0, 1, 0);

        @(negedge clk); #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
